fft_peak_detector: RTL and testbench

- Consumes the FFT result stream read out of the FFT RAM after the FFT control unit asserts done. The readout address counter presents bin k on the k-th consecutive done-high cycle, starting at k=0.
- Computes an approximate magnitude per bin and tracks the largest bin in 1..N/2-1, skipping DC and the mirrored half.
- Reports the peak index and magnitude once per frame to the downstream pitch/note logic.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_peak_detector_if.sv | 29 ++
 rtl/fft_mag_approx.sv | 22 ++
 rtl/fft_peak_detector.sv | 171 +++++++++++++++++
 tb/tb_fft_peak_detector.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT peak detector.
// Optional feature macro used across the slice: PEAK_GATE_EN (noise gate).
package fft_pkg;

  localparam int bit_width = 16;
  localparam int N         = 512;
  localparam int M         = 9;
  localparam int HALF_N    = N / 2;

  typedef logic [bit_width-1:0] mag_t;
  typedef logic [M-1:0]         bin_idx_t;

  // First bin outside the searched half-spectrum, and the last bin inside it.
  localparam bin_idx_t HALF_IDX = bin_idx_t'(HALF_N);
  localparam bin_idx_t LAST_BIN = bin_idx_t'(HALF_N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} peak_state_t;

  // Tag travelling alongside a RAM read so the bin index lines up with rd_data.
  typedef struct packed {
    logic     valid;
    bin_idx_t idx;
  } tag_t;

  // Absolute value of a two's-complement component as an unsigned magnitude;
  // the most negative input maps to 2^(bit_width-1) without saturation.
  function automatic mag_t abs_u(input logic signed [bit_width-1:0] x);
    return x[bit_width-1] ? mag_t'(-x) : mag_t'(x);
  endfunction

endpackage

// File: rtl/fft_peak_detector_if.sv
// Readout stream and frame-result bundle between the FFT RAM side and the
// peak detector. PEAK_GATE_EN adds the min_mag threshold and no_signal flag.
interface fft_peak_detector_if;
  import fft_pkg::*;

  logic                   done;
  logic [2*bit_width-1:0] rd_data;
  logic                   peak_valid;
  bin_idx_t               peak_idx;
  mag_t                   peak_mag;
  logic                   busy;
`ifdef PEAK_GATE_EN
  mag_t                   min_mag;
  logic                   no_signal;
`endif

`ifdef PEAK_GATE_EN
  modport master (output done, rd_data, min_mag,
                  input  peak_valid, peak_idx, peak_mag, busy, no_signal);
  modport slave  (input  done, rd_data, min_mag,
                  output peak_valid, peak_idx, peak_mag, busy, no_signal);
`else
  modport master (output done, rd_data,
                  input  peak_valid, peak_idx, peak_mag, busy);
  modport slave  (input  done, rd_data,
                  output peak_valid, peak_idx, peak_mag, busy);
`endif

endinterface

// File: rtl/fft_mag_approx.sv
// Alpha-max-plus-beta-min magnitude estimate: max(|re|,|im|) + min(|re|,|im|)/2.
// The result never exceeds 3*2^(bit_width-2), so it fits in bit_width bits.
module fft_mag_approx
  import fft_pkg::*;
(
  input  logic signed [bit_width-1:0] re,
  input  logic signed [bit_width-1:0] im,
  output mag_t                        mag
);

  mag_t a;
  mag_t b;

  // Pure combinational estimate of one bin's magnitude.
  always_comb begin
    a = abs_u(re);
    b = abs_u(im);
    if (a >= b) mag = a + (b >> 1);
    else        mag = b + (a >> 1);
  end

endmodule

// File: rtl/fft_peak_detector.sv
// Scans bins 1..N/2-1 of one FFT readout frame and reports the largest bin.
// Optional noise gate: define PEAK_GATE_EN to add min_mag / no_signal.
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  fft_peak_detector_if.slave  bus
);

  peak_state_t             state_q, state_d;
  logic                    done_q, done_d;
  logic                    armed_q, armed_d;
  bin_idx_t                issue_cnt_q, issue_cnt_d;
  tag_t [RD_LAT-1:0]       tag_q, tag_d;
  mag_t                    best_mag_q, best_mag_d;
  bin_idx_t                best_idx_q, best_idx_d;
  logic                    peak_valid_q, peak_valid_d;
  bin_idx_t                peak_idx_q, peak_idx_d;
  mag_t                    peak_mag_q, peak_mag_d;
  logic                    busy_q, busy_d;
`ifdef PEAK_GATE_EN
  logic                    no_signal_q, no_signal_d;
`endif

  tag_t  new_tag;
  tag_t  acc_tag;
  logic  flush;
  logic  rise;
  logic  better;
  logic  last_bin;
  mag_t  mag;

  fft_mag_approx u_mag (
    .re  (bus.rd_data[2*bit_width-1:bit_width]),
    .im  (bus.rd_data[bit_width-1:0]),
    .mag (mag)
  );

  // armed_q blocks a done level that is already high out of reset from
  // looking like a fresh rising edge.
  assign rise     = bus.done & ~done_q & armed_q;
  assign acc_tag  = tag_q[RD_LAT-1];
  assign better   = acc_tag.valid && (acc_tag.idx != '0) &&
                    (acc_tag.idx <= LAST_BIN) && (mag > best_mag_q);
  assign last_bin = acc_tag.valid && (acc_tag.idx == LAST_BIN);

  // Next-state logic for the IDLE -> SCAN -> REPORT frame sequence.
  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a
    // combinational output unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    done_d       = bus.done;
    armed_d      = armed_q | ~bus.done;
    issue_cnt_d  = issue_cnt_q;
    best_mag_d   = best_mag_q;
    best_idx_d   = best_idx_q;
    peak_valid_d = 1'b0;
    peak_idx_d   = peak_idx_q;
    peak_mag_d   = peak_mag_q;
`ifdef PEAK_GATE_EN
    no_signal_d  = no_signal_q;
`endif
    new_tag      = '0;
    flush        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          // The rising-edge cycle itself addresses bin 0.
          state_d     = SCAN;
          issue_cnt_d = bin_idx_t'(1);
          best_mag_d  = '0;
          best_idx_d  = '0;
          new_tag     = '{valid: 1'b1, idx: '0};
        end
      end

      SCAN: begin
        // Only the lower half is tagged; later addresses are never compared.
        if (bus.done && (issue_cnt_q < HALF_IDX)) begin
          new_tag     = '{valid: 1'b1, idx: issue_cnt_q};
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (better) begin
          best_mag_d = mag;
          best_idx_d = acc_tag.idx;
        end
        if (last_bin) begin
          state_d      = REPORT;
          peak_valid_d = 1'b1;
          peak_idx_d   = best_idx_d;
          peak_mag_d   = best_mag_d;
`ifdef PEAK_GATE_EN
          if (best_mag_d < bus.min_mag) begin
            no_signal_d = 1'b1;
            peak_idx_d  = '0;
          end else begin
            no_signal_d = 1'b0;
          end
`endif
        end else if (!bus.done) begin
          // Frame cut short: drop in-flight reads and keep the last result.
          state_d = IDLE;
          flush   = 1'b1;
        end
      end

      REPORT: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    tag_d    = '0;
    tag_d[0] = new_tag;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    if (flush) tag_d = '0;

    busy_d = (state_d == SCAN);
  end

  // State, pipeline tags and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
      issue_cnt_q  <= '0;
      // NOTE: the tag pipeline is reset because a stale valid tag after
      // reset would be accepted as a real bin.
      tag_q        <= '0;
      best_mag_q   <= '0;
      best_idx_q   <= '0;
      peak_valid_q <= 1'b0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      busy_q       <= 1'b0;
`ifdef PEAK_GATE_EN
      no_signal_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      done_q       <= done_d;
      armed_q      <= armed_d;
      issue_cnt_q  <= issue_cnt_d;
      tag_q        <= tag_d;
      best_mag_q   <= best_mag_d;
      best_idx_q   <= best_idx_d;
      peak_valid_q <= peak_valid_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      busy_q       <= busy_d;
`ifdef PEAK_GATE_EN
      no_signal_q  <= no_signal_d;
`endif
    end
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_idx   = peak_idx_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.busy       = busy_q;
`ifdef PEAK_GATE_EN
  assign bus.no_signal  = no_signal_q;
`endif

endmodule

// File: tb/tb_fft_peak_detector.sv
// Scoreboard bench for fft_peak_detector: frames are driven from a bin table,
// expected reports are queued at issue time and checked by a monitor.
module tb_fft_peak_detector;
  import fft_pkg::*;

  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_peak_detector_if bus ();

  fft_peak_detector #(.RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int idx;
    int mag;
    int ns;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          pos_cnt  = 0;
  logic [31:0] frame_mem [0:N-1];

  always @(posedge clk) pos_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every peak_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && bus.peak_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_peak_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("report_cycle", pos_cnt, e.cyc);
        check("peak_idx", 32'(bus.peak_idx), e.idx);
        check("peak_mag", 32'(bus.peak_mag), e.mag);
`ifdef PEAK_GATE_EN
        check("no_signal", 32'(bus.no_signal), e.ns);
`endif
      end
    end
  end

  task automatic clear_frame();
    for (int k = 0; k < N; k++) frame_mem[k] = '0;
  endtask

  task automatic set_bin(input int k, input int re, input int im);
    frame_mem[k] = {re[15:0], im[15:0]};
  endtask

  // Drive one readout of len done-high cycles; bin k appears RD_LAT+k cycles
  // after the first done-high cycle.
  task automatic run_frame(input int len, input bit expect_rep,
                           input int e_idx, input int e_mag, input int e_ns);
    int start;
    @(negedge clk);
    start = pos_cnt;
    if (expect_rep) sb_q.push_back('{start + RD_LAT + HALF_N, e_idx, e_mag, e_ns});
    for (int j = 0; j < len; j++) begin
      bus.done    = 1'b1;
      bus.rd_data = (j >= RD_LAT) ? frame_mem[j-RD_LAT] : '0;
      if (j == 10) check("busy_in_scan", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    bus.done    = 1'b0;
    bus.rd_data = '0;
    repeat (4) @(negedge clk);
    check("busy_after_frame", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    bus.done    = 1'b0;
    bus.rd_data = '0;
`ifdef PEAK_GATE_EN
    bus.min_mag = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_peak_valid", 32'(bus.peak_valid), 32'd0);
    check("rst_peak_idx", 32'(bus.peak_idx), 32'd0);
    check("rst_peak_mag", 32'(bus.peak_mag), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
`ifdef PEAK_GATE_EN
    check("rst_no_signal", 32'(bus.no_signal), 32'd0);
`endif

    // done already high when reset releases must not start a scan
    bus.done = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_scan_done_high_at_reset", 32'(bus.busy), 32'd0);
    bus.done = 1'b0;
    repeat (3) @(negedge clk);

    // single tone: |1000| + |−500|/2
    clear_frame();
    set_bin(37, 1000, -500);
    run_frame(512, 1'b1, 37, 1250, 0);

    // DC and mirrored half excluded; tie keeps the lower index
    clear_frame();
    set_bin(0, 20000, 0);
    set_bin(300, 20000, 0);
    set_bin(10, 500, 500);
    set_bin(20, 500, 500);
    run_frame(512, 1'b1, 10, 750, 0);

    // all-zero frame still reports
    clear_frame();
    run_frame(512, 1'b1, 0, 0, 0);

    // most negative components: 32768 + 16384
    clear_frame();
    set_bin(5, -32768, -32768);
    run_frame(512, 1'b1, 5, 49152, 0);

    // abort after 100 cycles: no report, previous result held
    clear_frame();
    set_bin(50, 9000, 0);
    run_frame(100, 1'b0, 0, 0, 0);
    check("abort_held_idx", 32'(bus.peak_idx), 32'd5);
    check("abort_held_mag", 32'(bus.peak_mag), 32'd49152);

    // last searched bin, done held exactly until it is read
    clear_frame();
    set_bin(255, 0, 7);
    run_frame(HALF_N + RD_LAT, 1'b1, 255, 7, 0);

    // first searched bin beats a larger bin in the mirrored half
    clear_frame();
    set_bin(1, 100, 0);
    set_bin(256, 30000, 0);
    run_frame(512, 1'b1, 1, 100, 0);

    // reset in the middle of a scan
    clear_frame();
    set_bin(37, 1000, -500);
    @(negedge clk);
    for (int j = 0; j < 50; j++) begin
      bus.done    = 1'b1;
      bus.rd_data = (j >= RD_LAT) ? frame_mem[j-RD_LAT] : '0;
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check("midrst_peak_idx", 32'(bus.peak_idx), 32'd0);
    check("midrst_peak_mag", 32'(bus.peak_mag), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_no_rescan", 32'(bus.busy), 32'd0);
    bus.done    = 1'b0;
    bus.rd_data = '0;
    repeat (3) @(negedge clk);

    // a fresh frame after the reset scans normally
    run_frame(512, 1'b1, 37, 1250, 0);

`ifdef PEAK_GATE_EN
    clear_frame();
    set_bin(40, 1000, 0);
    bus.min_mag = 16'd2000;
    run_frame(512, 1'b1, 0, 1000, 1);
    bus.min_mag = 16'd500;
    run_frame(512, 1'b1, 40, 1000, 0);
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
